qpd_capture: RTL and testbench

QPD_CAPTURE -- requirements
Module: qpd_capture

---
 rtl/qpd_pkg.sv | 17 +
 rtl/capture_ram.sv | 50 +++++
 rtl/qpd_capture.sv | 167 ++++++++++++++++
 tb/tb_qpd_capture.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/qpd_pkg.sv
// qpd_pkg
// Shared definitions for the quarter-period-delay capture block:
//   - default ADC sample width and capture buffer depth
//   - capture FSM state enumeration
package qpd_pkg;

    localparam int QPD_DATA_W = 16;
    localparam int QPD_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2,
        ST_READOUT = 2'd3
    } qpd_state_e;

endpackage : qpd_pkg

// File: rtl/capture_ram.sv
// capture_ram
// Simple dual-port sample buffer: synchronous write port, synchronous read
// port with a registered output. Array contents are not reset; only the
// read-data register is, so the block output is known after reset.
// Ports:
//   sclock   - clock
//   rstn     - async active-low reset (read register only)
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates one cycle later
//   rd_addr  - read address
//   rd_data  - registered read data (holds when rd_en is low)
module capture_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              sclock,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array write port; contents intentionally left unreset.
    always_ff @(posedge sclock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared on reset so the output starts at zero.
    always_ff @(posedge sclock or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : capture_ram

// File: rtl/qpd_capture.sv
// qpd_capture
// Triggered ADC capture buffer. A trigger in IDLE starts capturing the next
// num_samples valid ADC samples (0 = DEPTH); once full the buffer is read out
// one sample per rd_en, after which the block returns to IDLE.
// Ports:
//   sclock       - sample clock
//   rstn         - async active-low reset
//   trigger      - capture start pulse
//   num_samples  - sample count, latched on the accepted trigger
//   adc_valid    - adc_data qualifier
//   adc_data     - ADC sample
//   rd_en        - readout request
//   rd_data      - read sample (registered)
//   rd_valid     - rd_data qualifier (registered)
//   busy         - high while capturing
//   done         - high while data is waiting / being read out
//   missed       - sticky: a trigger arrived while not IDLE
module qpd_capture
    import qpd_pkg::*;
#(
    parameter int DATA_W = QPD_DATA_W,
    parameter int DEPTH  = QPD_DEPTH
) (
    input  logic              sclock,
    input  logic              rstn,
    input  logic              trigger,
    input  logic [7:0]        num_samples,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              missed
);

    localparam int AW    = $clog2(DEPTH);
    // One extra bit so a full buffer (count == DEPTH) does not wrap to 0.
    localparam int PTR_W = AW + 1;

    qpd_state_e       state_q, state_d;
    logic [PTR_W-1:0] target_q, target_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             missed_q, missed_d;
    logic             rd_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             ram_we_s;
    logic             ram_re_s;

    // Next-state, pointer and flag logic for the capture FSM.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        missed_d = missed_q;
        ram_we_s = 1'b0;
        ram_re_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    // Zero (or anything beyond the buffer) means a full buffer.
                    if ((num_samples == 8'd0) || (32'(num_samples) > 32'(DEPTH))) begin
                        target_d = PTR_W'(DEPTH);
                    end else begin
                        target_d = PTR_W'(num_samples);
                    end
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    missed_d = 1'b0;
                    state_d  = ST_CAPTURE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (trigger) begin
                    missed_d = 1'b1;
                end else begin
                    missed_d = missed_q;
                end
                if (adc_valid) begin
                    ram_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
                    if ((wr_ptr_q + PTR_W'(1'b1)) == target_q) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_READY, ST_READOUT: begin
                if (trigger) begin
                    missed_d = 1'b1;
                end else begin
                    missed_d = missed_q;
                end
                if (rd_en && (rd_ptr_q < wr_ptr_q)) begin
                    ram_re_s = 1'b1;
                    if ((rd_ptr_q + PTR_W'(1'b1)) == wr_ptr_q) begin
                        // Last sample handed out: release the buffer.
                        rd_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
                        state_d  = ST_READOUT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered-output update.
    always_ff @(posedge sclock or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            missed_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            missed_q   <= missed_d;
            rd_valid_q <= ram_re_s;
            // Status flags registered from the next state so they track state_q.
            busy_q     <= (state_d == ST_CAPTURE);
            done_q     <= (state_d == ST_READY) || (state_d == ST_READOUT);
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .sclock  (sclock),
        .rstn    (rstn),
        .wr_en   (ram_we_s),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (adc_data),
        .rd_en   (ram_re_s),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign missed   = missed_q;

endmodule : qpd_capture

// File: tb/tb_qpd_capture.sv
// Testbench for qpd_capture: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model of the capture buffer.
module tb_qpd_capture;

    logic        sclock;
    logic        rstn;
    logic        trigger;
    logic [7:0]  num_samples;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        missed;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: captured samples kept in a queue.
    bit          m_cap;      // collecting samples
    bit          m_hold;     // samples waiting / being read
    bit          m_missed;
    int          m_target;
    int          m_rd;
    logic [15:0] m_buf[$];
    bit          e_rv;
    logic [15:0] e_rd;

    qpd_capture #(.DATA_W(16), .DEPTH(256)) dut (
        .sclock      (sclock),
        .rstn        (rstn),
        .trigger     (trigger),
        .num_samples (num_samples),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .missed      (missed)
    );

    initial sclock = 1'b0;
    always #5 sclock = ~sclock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cap = 1'b0; m_hold = 1'b0; m_missed = 1'b0;
        m_target = 0; m_rd = 0; m_buf.delete();
        e_rv = 1'b0; e_rd = 16'h0000;
    endtask

    // Apply one cycle of inputs to the model (what should happen at the edge).
    task automatic model_step();
        e_rv = 1'b0;
        if (!m_cap && !m_hold) begin
            if (trigger) begin
                m_target = (num_samples == 8'd0) ? 256 : int'(num_samples);
                m_buf.delete();
                m_rd = 0;
                m_missed = 1'b0;
                m_cap = 1'b1;
            end
        end else if (m_cap) begin
            if (trigger) m_missed = 1'b1;
            if (adc_valid) begin
                m_buf.push_back(adc_data);
                if (m_buf.size() == m_target) begin
                    m_cap = 1'b0;
                    m_hold = 1'b1;
                end
            end
        end else begin
            if (trigger) m_missed = 1'b1;
            if (rd_en && (m_rd < m_buf.size())) begin
                e_rv = 1'b1;
                e_rd = m_buf[m_rd];
                m_rd++;
                if (m_rd == m_buf.size()) m_hold = 1'b0;
            end
        end
    endtask

    task automatic step(input logic trig, input int ns, input logic av,
                        input logic [15:0] ad, input logic re);
        trigger = trig; num_samples = 8'(ns); adc_valid = av; adc_data = ad; rd_en = re;
        model_step();
        @(posedge sclock);
        #1;
        check_eq("busy", 32'(busy), 32'(m_cap));
        check_eq("done", 32'(done), 32'(m_hold));
        check_eq("missed", 32'(missed), 32'(m_missed));
        check_eq("rd_valid", 32'(rd_valid), 32'(e_rv));
        if (e_rv) check_eq("rd_data", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Pulse reset away from the clock edge; outputs must clear at once.
    task automatic pulse_reset();
        trigger = 1'b0; adc_valid = 1'b0; rd_en = 1'b0;
        rstn = 1'b0;
        #2;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_missed", 32'(missed), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        @(posedge sclock);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; trigger = 1'b0; num_samples = 8'd0;
        adc_valid = 1'b0; adc_data = 16'h0000; rd_en = 1'b0;
        model_reset();
        #3;
        pulse_reset();

        // Basic: 4 samples, adc_valid every third cycle.
        step(1'b1, 4, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b0, 16'h0000, 1'b0);
            step(1'b0, 0, 1'b0, 16'h0000, 1'b0);
            step(1'b0, 0, 1'b1, 16'h0010 + 16'(i), 1'b0);
        end
        check_eq("s1_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
            check_eq("s1_data", 32'(rd_data), 32'h10 + 32'(i));
        end
        step(1'b0, 0, 1'b0, 16'h0000, 1'b0);
        check_eq("s1_idle", 32'({busy, done}), 32'd0);

        // Sample on the trigger cycle itself is not stored.
        step(1'b1, 2, 1'b1, 16'h00AA, 1'b0);
        step(1'b0, 0, 1'b1, 16'h0055, 1'b0);
        step(1'b0, 0, 1'b1, 16'h0056, 1'b0);
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
        check_eq("trig_cycle_data", 32'(rd_data), 32'h55);
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);

        // Full-depth capture: ramp 0..255, num_samples = 0.
        step(1'b1, 0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b0, 0, 1'b1, 16'(i), 1'b0);
        check_eq("full_wr_ptr", 32'(dut.wr_ptr_q), 32'd256);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
            check_eq("ramp_data", 32'(rd_data), 32'(i));
        end
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);

        // Missed triggers during capture and readout; rd_en held during capture.
        step(1'b1, 3, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 9, 1'b1, 16'h0100, 1'b1);
        step(1'b1, 9, 1'b1, 16'h0101, 1'b1);
        check_eq("missed_cap", 32'(missed), 32'd1);
        step(1'b0, 0, 1'b1, 16'h0102, 1'b0);
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 0, 1'b0, 16'h0000, 1'b1);
        check_eq("missed_ro_data", 32'(rd_data), 32'h101);
        step(1'b1, 0, 1'b0, 16'h0000, 1'b1);   // trigger with final read
        check_eq("missed_final", 32'(missed), 32'd1);
        check_eq("final_data", 32'(rd_data), 32'h102);
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);   // rd_en after last sample
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1, 1'b0, 16'h0000, 1'b0);
        check_eq("missed_clear", 32'(missed), 32'd0);
        step(1'b0, 0, 1'b1, 16'h0777, 1'b0);
        step(1'b0, 0, 1'b0, 16'h0000, 1'b1);

        // Reset after 2 of 8 samples, then a fresh 8-sample capture.
        step(1'b1, 8, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 0, 1'b1, 16'h0E00, 1'b0);
        step(1'b0, 0, 1'b1, 16'h0E01, 1'b0);
        pulse_reset();
        step(1'b1, 8, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 16'h0C00 + 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 1'b0, 16'h0000, 1'b1);
            check_eq("post_rst_data", 32'(rd_data), 32'h0C00 + 32'(i));
        end
        idle_cycles(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic t;
            int   ns;
            t  = ($urandom_range(0, 15) == 0);
            ns = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
            step(t, ns, 1'(($urandom & 1)), 16'($urandom), 1'(($urandom_range(0, 2) != 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qpd_capture
